// File: rtl/shift_ctrl_pkg.sv
// Shared types and helpers for the serializer controller.
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Ceiling log2, never less than 1 so a counter always has at least one bit.
  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/shift_reg_load.sv
// Parallel-load, left-shift register; load wins over shift.
module shift_reg_load #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic             fill,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load a word, or shift toward the MSB inserting the fill bit.
  always_ff @(posedge clk) begin
    if (rst)           q <= '0;
    else if (load)     q <= d;
    else if (shift_en) q <= {q[WIDTH-2:0], fill};
  end

endmodule

// File: rtl/shift_ser_ctrl.sv
// Frame controller: accepts a word, shifts it out MSB first with framing
// strobes, then idles GAP cycles before accepting the next word.
module shift_ser_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int GAP   = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic             sdout,
  output logic             sframe,
  output logic             sstart,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int BW = clog2(WIDTH);
  localparam int GW = clog2(GAP + 1);

  state_t          state, state_nx;
  logic [BW-1:0]   bit_cnt, bit_cnt_nx;
  logic [GW-1:0]   gap_cnt, gap_cnt_nx;
  logic            accept;
  logic            frame_done;
  logic            clr_sr;
  logic [WIDTH-1:0] sr_q;
  logic            unused_sr_lsbs;

  assign in_ready = (state == ST_IDLE) & ~rst;
  assign accept   = in_valid & in_ready;

  // The shift register drains to zero after WIDTH shifts, and is cleared on
  // abort, so its MSB is a clean flop-driven sdout outside of SHIFT.
  shift_reg_load #(.WIDTH(WIDTH)) u_sr (
    .clk      (clk),
    .rst      (rst),
    .load     (accept | clr_sr),
    .shift_en ((state == ST_SHIFT) & ~abort),
    .fill     (1'b0),
    .d        (accept ? in_data : '0),
    .q        (sr_q)
  );

  assign sdout          = sr_q[WIDTH-1];
  assign unused_sr_lsbs = ^sr_q[WIDTH-2:0];

  // Next-state and counter update; abort takes priority over the last bit.
  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    gap_cnt_nx = gap_cnt;
    frame_done = 1'b0;
    clr_sr     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nx   = ST_SHIFT;
          bit_cnt_nx = BW'(WIDTH - 1);
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_nx = ST_IDLE;
          clr_sr   = 1'b1;
        end else begin
          bit_cnt_nx = bit_cnt - BW'(1);
          if (bit_cnt == '0) begin
            frame_done = 1'b1;
            if (GAP > 0) begin
              state_nx   = ST_GAP;
              gap_cnt_nx = GW'(GAP > 0 ? GAP - 1 : 0);
            end else begin
              state_nx = ST_IDLE;
            end
          end
        end
      end
      ST_GAP: begin
        if (abort || gap_cnt == '0) state_nx = ST_IDLE;
        else                        gap_cnt_nx = gap_cnt - GW'(1);
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_nx;
      bit_cnt <= bit_cnt_nx;
      gap_cnt <= gap_cnt_nx;
    end
  end

  // Strobes are registered from the next state so they line up with sdout.
  always_ff @(posedge clk) begin
    if (rst) begin
      sframe    <= 1'b0;
      sstart    <= 1'b0;
      busy      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      sframe <= (state_nx == ST_SHIFT);
      sstart <= accept;
      busy   <= (state_nx != ST_IDLE);
      if (frame_done) frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

endmodule
